// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: accepts one operation, shifts up to STEP
// positions per clock, then holds the result under a valid/ready handshake.
`timescale 1ns/1ps

module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRL = 2'b11
  } mode_t;

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] remaining_nxt;
  logic [AMT_W-1:0] step_d;

  // Distance for this clock: never more than STEP, so the datapath is a
  // STEP-input mux regardless of WIDTH.
  always_comb begin
    step_d        = (remaining > AMT_W'(STEP)) ? AMT_W'(STEP) : remaining;
    remaining_nxt = remaining - step_d;
  end

  // NOTE: work_nxt gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    work_nxt = work;
    for (int k = 1; k <= STEP; k++) begin
      if (step_d == AMT_W'(k)) begin
        case (mode_q)
          MODE_SLL: work_nxt = work << k;
          MODE_SRL: work_nxt = work >> k;
          MODE_SRA: work_nxt = WIDTH'($signed(work) >>> k);
          MODE_ROR: work_nxt = (work >> k) | (work << (WIDTH - k));
          default:  work_nxt = work;
        endcase
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      work      <= '0;
      mode_q    <= MODE_SLL;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work      <= in_data;
            mode_q    <= mode_t'(mode);
            remaining <= amount;
            in_ready  <= 1'b0;
            if (amount == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= work_nxt;
          remaining <= remaining_nxt;
          if (remaining_nxt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = work;
  assign out_zero = (work == '0);

  // Handshake flags are registered copies of the state decode.
  a_ready_decode: assert property (@(posedge clk) disable iff (rst)
    in_ready == (state == IDLE));
  a_valid_decode: assert property (@(posedge clk) disable iff (rst)
    out_valid == (state == DONE));
  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_data == $past(out_data)));

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and randomized checks of iter_shifter at 16/4, 32/3 and 8/1.
`timescale 1ns/1ps

module tb_iter_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0, out_zero16;
  logic [15:0] in_data16 = 0, out_data16;
  logic [3:0]  amount16 = 0;
  logic [1:0]  mode16 = 0;

  logic        in_valid32 = 0, in_ready32, out_valid32, out_ready32 = 0, out_zero32;
  logic [31:0] in_data32 = 0, out_data32;
  logic [4:0]  amount32 = 0;
  logic [1:0]  mode32 = 0;

  logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, out_zero8;
  logic [7:0]  in_data8 = 0, out_data8;
  logic [2:0]  amount8 = 0;
  logic [1:0]  mode8 = 0;

  iter_shifter u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data16), .amount(amount16), .mode(mode16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_zero(out_zero16));

  iter_shifter #(.WIDTH(32), .STEP(3)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .amount(amount32), .mode(mode32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_data(out_data32), .out_zero(out_zero32));

  iter_shifter #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .amount(amount8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_zero(out_zero8));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Single-step reference: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int w,
                                            input int amt, input logic [1:0] m);
    logic [63:0] mask, xv, r;
    mask = (64'd1 << w) - 64'd1;
    xv   = x & mask;
    case (m)
      2'b00:   r = xv << amt;
      2'b11:   r = xv >> amt;
      2'b01: begin
        r = xv >> amt;
        if (xv[w-1]) r = r | ~(mask >> amt);
      end
      default: r = (xv >> amt) | (xv << (w - amt));
    endcase
    return r & mask;
  endfunction

  task automatic run16(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                       output logic [15:0] res, output logic zero, output int lat);
    @(negedge clk);
    in_valid16 = 1; in_data16 = d; amount16 = a; mode16 = m;
    @(posedge clk); #1;
    // Scramble inputs after accept; the operation in flight must not see them.
    in_valid16 = 0; in_data16 = 16'hDEAD; amount16 = 4'hF; mode16 = 2'b00;
    lat = 1;
    while (!out_valid16 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_data16;
    zero = out_zero16;
  endtask

  task automatic release16();
    @(negedge clk);
    out_ready16 = 1;
    @(posedge clk); #1;
    out_ready16 = 0;
  endtask

  task automatic sweep32();
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 32; a++) begin
        logic [31:0] d, res;
        int cyc;
        bit got;
        d = $urandom();
        res = '0;
        @(negedge clk);
        out_ready32 = 0; in_valid32 = 1; in_data32 = d; amount32 = 5'(a); mode32 = 2'(m);
        @(posedge clk); #1;
        in_valid32 = 0; in_data32 = ~d;
        got = 0; cyc = 0;
        while (!got && cyc < 100) begin
          @(negedge clk);
          cyc++;
          out_ready32 = 1'($urandom_range(0, 1));
          if (out_valid32 && out_ready32) begin
            res = out_data32;
            got = 1;
          end
        end
        @(posedge clk); #1;
        out_ready32 = 0;
        if (!got) check($sformatf("sweep32 m%0d a%0d timeout", m, a), 64'd0, 64'd1);
        else check($sformatf("sweep32 m%0d a%0d d=%0h", m, a, d), 64'(res),
                   ref_shift(64'(d), 32, a, 2'(m)));
      end
    end
  endtask

  task automatic sweep8();
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 8; a++) begin
        logic [7:0] d, res;
        int cyc;
        bit got;
        d = 8'($urandom());
        res = '0;
        @(negedge clk);
        out_ready8 = 0; in_valid8 = 1; in_data8 = d; amount8 = 3'(a); mode8 = 2'(m);
        @(posedge clk); #1;
        in_valid8 = 0; in_data8 = ~d;
        got = 0; cyc = 0;
        while (!got && cyc < 100) begin
          @(negedge clk);
          cyc++;
          out_ready8 = 1'($urandom_range(0, 1));
          if (out_valid8 && out_ready8) begin
            res = out_data8;
            got = 1;
          end
        end
        @(posedge clk); #1;
        out_ready8 = 0;
        if (!got) check($sformatf("sweep8 m%0d a%0d timeout", m, a), 64'd0, 64'd1);
        else check($sformatf("sweep8 m%0d a%0d d=%0h", m, a, d), 64'(res),
                   ref_shift(64'(d), 8, a, 2'(m)));
      end
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  mode;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] res;
    logic        zero;
    int          lat;

    vecs[0]  = '{16'h0001, 4'd15, 2'b00, 16'h8000, 5};
    vecs[1]  = '{16'h8000, 4'd15, 2'b11, 16'h0001, 5};
    vecs[2]  = '{16'h0000, 4'd3,  2'b00, 16'h0000, 2};
    vecs[3]  = '{16'h8000, 4'd15, 2'b01, 16'hFFFF, 5};
    vecs[4]  = '{16'h7FF0, 4'd4,  2'b01, 16'h07FF, 2};
    vecs[5]  = '{16'h1234, 4'd4,  2'b10, 16'h4123, 2};
    vecs[6]  = '{16'h0001, 4'd1,  2'b10, 16'h8000, 2};
    vecs[7]  = '{16'hA5A5, 4'd0,  2'b00, 16'hA5A5, 1};
    vecs[8]  = '{16'hA5A5, 4'd0,  2'b01, 16'hA5A5, 1};
    vecs[9]  = '{16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1};
    vecs[10] = '{16'hA5A5, 4'd0,  2'b11, 16'hA5A5, 1};
    vecs[11] = '{16'hF0F0, 4'd5,  2'b11, 16'h0787, 3};
    vecs[12] = '{16'h00FF, 4'd8,  2'b00, 16'hFF00, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready16), 64'd1);
    check("reset out_valid", 64'(out_valid16), 64'd0);
    check("reset out_data", 64'(out_data16), 64'd0);
    check("reset out_zero", 64'(out_zero16), 64'd1);
    @(negedge clk);
    rst = 0;

    // Directed vectors
    foreach (vecs[i]) begin
      check($sformatf("vec%0d in_ready", i), 64'(in_ready16), 64'd1);
      run16(vecs[i].data, vecs[i].amt, vecs[i].mode, res, zero, lat);
      check($sformatf("vec%0d data", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].exp == 16'h0));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      release16();
    end

    // Backpressure, with new requests offered while busy: SLL 0x0003 by 9
    @(negedge clk);
    in_valid16 = 1; in_data16 = 16'h0003; amount16 = 4'd9; mode16 = 2'b00;
    @(posedge clk); #1;
    in_data16 = 16'hFFFF; amount16 = 4'd1; mode16 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid16 = (i % 2 == 0);
      @(posedge clk); #1;
    end
    check("bp out_valid", 64'(out_valid16), 64'd1);
    check("bp data", 64'(out_data16), 64'h0600);
    in_valid16 = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d data", i), 64'(out_data16), 64'h0600);
      check($sformatf("bp hold%0d in_ready", i), 64'(in_ready16), 64'd0);
      check($sformatf("bp hold%0d out_valid", i), 64'(out_valid16), 64'd1);
    end
    @(negedge clk);
    in_valid16 = 0;
    out_ready16 = 1;
    @(posedge clk); #1;
    out_ready16 = 0;
    check("bp release in_ready", 64'(in_ready16), 64'd1);
    check("bp release out_valid", 64'(out_valid16), 64'd0);
    @(posedge clk); #1;
    check("bp no ghost op", 64'(out_valid16), 64'd0);

    // Reset during SHIFT abandons the operation
    @(negedge clk);
    in_valid16 = 1; in_data16 = 16'h0001; amount16 = 4'd15; mode16 = 2'b00;
    @(posedge clk); #1;
    in_valid16 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("midrst in_ready", 64'(in_ready16), 64'd1);
    check("midrst out_valid", 64'(out_valid16), 64'd0);
    check("midrst out_data", 64'(out_data16), 64'd0);
    check("midrst out_zero", 64'(out_zero16), 64'd1);
    @(negedge clk);
    rst = 0;
    run16(16'h00FF, 4'd8, 2'b10, res, zero, lat);
    check("post-rst ror data", 64'(res), 64'hFF00);
    check("post-rst ror latency", 64'(lat), 64'd3);
    release16();

    sweep32();
    sweep8();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised, multi-cycle shift/rotate unit. It replaces the fixed 16-bit single-cycle shifter wherever a wider datapath, an extra logical-right mode, or a shorter critical path is needed. The unit accepts one operation through a valid/ready handshake, then shifts by up to STEP positions per clock. It holds the result under a valid/ready output handshake. It sits in the execute stage beside the ALU, and the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- WIDTH, 16: operand/result width in bits; power of two, 4..64.
- STEP, 4: maximum shift distance applied per clock; 1..WIDTH-1.
- AMT_W, $clog2(WIDTH): derived; width of `amount`; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_data  input  WIDTH  operand.
- amount  input  AMT_W  shift distance, 0..WIDTH-1.
- mode  input  2  shift mode: 00 logical left, 01 arithmetic right, 10 rotate right, 11 logical right.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  result.
- out_zero  output  1  out_data == 0; valid while out_valid.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: busy.
  - DONE: `out_valid`=1.
- IDLE transitions:
  - On accept (`in_valid & in_ready`), latch `in_data` into the working register, latch `mode`, and set remaining = `amount`.
  - If `amount`==0, go to DONE; otherwise go to SHIFT.
- SHIFT, each clock:
  - Compute d = min(remaining, STEP).
  - Shift the working register by d in the latched mode, and set remaining -= d.
  - If the new remaining == 0, go to DONE.
- Mode fill rules:
  - SLL fills zeros from the LSB.
  - SRL fills zeros from the MSB.
  - SRA replicates the working-register MSB, which equals the original operand's MSB.
  - ROR moves the bits shifted out of the LSB end into the MSB end.
- DONE:
  - `out_data` = working register, held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - No new operation is accepted in the same cycle; `in_ready`=0 in DONE.
- Inputs are ignored outside IDLE. Changes to `in_data`/`amount`/`mode` after accept do not affect the operation in flight.
- The result must equal the single-step reference: SLL = in<<amount, SRL = in>>amount, SRA = $signed(in)>>>amount, ROR = rotate right by amount.
- `out_zero` is a combinational decode of the working register.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1, `out_valid`=0.
  - `out_data`=0, `out_zero`=1, remaining=0.
- Reset mid-operation (SHIFT or DONE) abandons the operation. Reset values appear in the cycle after the reset edge. No result is emitted.
- Latency, counted in rising edges from the accept edge to the first cycle with `out_valid`=1: 1 + ceil(amount/STEP).
  - amount 0 → 1.
  - WIDTH=16, STEP=4, amount 15 → 5.
- Throughput: one operation per latency + 1 cycles, assuming `out_ready` is held high. The DONE→IDLE edge costs one cycle before the next accept.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid`/`out_ready`.
- `out_data` is held unchanged while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- Critical path: one STEP-wide mux stage per clock, independent of WIDTH/STEP ratio beyond the mux fan-in.

## Test plan
- WIDTH=16, STEP=4 (default) unless noted. Scoreboard every result against the single-step reference.
- SLL 0x0001 by 15 → 0x8000, `out_valid` 5 edges after accept, `out_zero`=0. SRL 0x8000 by 15 → 0x0001. SLL 0x0000 by 3 → 0x0000, `out_zero`=1.
- SRA 0x8000 by 15 → 0xFFFF. SRA 0x7FF0 by 4 → 0x07FF, latency 2. ROR 0x1234 by 4 → 0x4123. ROR 0x0001 by 1 → 0x8000.
- amount 0, every mode, operand 0xA5A5 → 0xA5A5 with latency 1.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `out_data` stable, `in_ready`=0. Toggle `in_valid` with a new operand during SHIFT → ignored. Release → IDLE next cycle.
- Assert `rst` during SHIFT of SLL 0x0001 by 15 → next cycle `in_ready`=1, `out_valid`=0, `out_data`=0. The following accept of ROR 0x00FF by 8 → 0xFF00.
- Random sweep at WIDTH=32, STEP=3 and WIDTH=8, STEP=1: all modes and amounts, with randomized `out_ready`.
